// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction cache.
// Imported by the cache top and its word-select mux.
package icache_pkg;

    localparam int BLOCK_WIDTH      = 128;
    localparam int WORD_WIDTH       = 32;
    localparam int OFFSET_BITS      = 2;
    localparam int BYTE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side bundle of the instruction cache.
// slave: the cache; master: the CPU/memory environment.
interface instruction_cache_if;

    logic         READ;
    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport slave (
        input  READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

endinterface

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction word out of a 128-bit line.
// Word 0 sits in the low bits of the line.
module icache_word_select
    import icache_pkg::*;
(
    input  logic [BLOCK_WIDTH-1:0] block,
    input  logic [OFFSET_BITS-1:0] offset,
    output logic [WORD_WIDTH-1:0]  word
);

    // Offset-driven 4:1 word mux
    always_comb begin
        word = block[31:0];
        unique case (offset)
            2'd0: word = block[31:0];
            2'd1: word = block[63:32];
            2'd2: word = block[95:64];
            2'd3: word = block[127:96];
            default: word = block[31:0];
        endcase
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with single-block refill.
// Hits answer combinationally; misses stall the fetch via BUSYWAIT.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3
)(
    input  logic                CLK,
    input  logic                RESET,
    instruction_cache_if.slave  bus
);

    localparam int LINES     = 1 << INDEX_BITS;
    localparam int BLK_BITS  = 32 - BYTE_OFFSET_BITS;
    localparam int TAG_BITS  = BLK_BITS - INDEX_BITS;

    logic [LINES-1:0]       valid_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [BLOCK_WIDTH-1:0] data_q [LINES];

    state_t                 state_q, state_d;
    logic [BLK_BITS-1:0]    miss_block_q;
    logic [BLOCK_WIDTH-1:0] fill_q;

    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic [OFFSET_BITS-1:0] offset;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [TAG_BITS-1:0]    fill_tag;
    logic [1:0]             unused_byte_sel;
    logic                   hit;
    logic                   busy;
    logic                   load_miss;
    logic                   capture;
    logic                   install;

    assign offset          = bus.ADDRESS[3:2];
    assign index           = bus.ADDRESS[BYTE_OFFSET_BITS +: INDEX_BITS];
    assign tag             = bus.ADDRESS[31 -: TAG_BITS];
    assign unused_byte_sel = bus.ADDRESS[1:0];
    assign fill_index      = miss_block_q[INDEX_BITS-1:0];
    assign fill_tag        = miss_block_q[BLK_BITS-1:INDEX_BITS];

    assign hit = bus.READ & valid_q[index] & (tag_q[index] == tag);

    icache_word_select u_word_select (
        .block  (data_q[index]),
        .offset (offset),
        .word   (bus.INSTRUCTION)
    );

    // Miss FSM: next state and control strobes
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        load_miss = 1'b0;
        capture   = 1'b0;
        install   = 1'b0;
        bus.MEM_READ = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.READ && !hit) begin
                    busy      = 1'b1;
                    load_miss = 1'b1;
                    state_d   = MEM_READ;
                end
            end
            MEM_READ: begin
                busy         = 1'b1;
                bus.MEM_READ = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    capture = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                install = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.BUSYWAIT    = RESET & busy;
    assign bus.MEM_ADDRESS = miss_block_q;

    // State register and valid bits, cleared by reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (install) valid_q[fill_index] <= 1'b1;
        end
    end

    // Miss address, fill buffer and line storage (no reset needed)
    always_ff @(posedge CLK) begin
        if (load_miss) miss_block_q <= bus.ADDRESS[31:BYTE_OFFSET_BITS];
        if (capture)   fill_q       <= bus.MEM_READDATA;
        if (install) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= fill_q;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: vector table of fetches
// plus hand-written mid-miss PC change, mid-miss reset and READ-low cases.
module tb_instruction_cache;

    localparam int LAT = 2;

    logic clk;
    logic rst;
    int   mcnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] sbq[$];
    logic [27:0] seen[$];

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] insn;
    } vec_t;

    vec_t tbl[10];

    instruction_cache_if bus ();

    instruction_cache #(.INDEX_BITS(3)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    function automatic logic [127:0] blk(input logic [27:0] b);
        logic [127:0] r;
        if (b == 28'h0) begin
            r = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        end else begin
            for (int i = 0; i < 4; i++)
                r[i*32 +: 32] = 32'hC000_0000 | {b, 4'h0} | 32'(i);
        end
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [127:0] b;
        int w;
        b = blk(a[31:4]);
        w = int'(a[3:2]);
        return b[w*32 +: 32];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: busy for LAT cycles after a read request appears
    always @(posedge clk) mcnt <= bus.MEM_READ ? mcnt + 1 : 0;
    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mcnt < LAT);
    assign bus.MEM_READDATA = blk(bus.MEM_ADDRESS);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input bit exp_miss, input logic [31:0] exp_insn);
        int busy;
        bit done;
        logic [31:0] e;
        bus.READ = 1'b1;
        bus.ADDRESS = addr;
        sbq.push_back(exp_insn);
        busy = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!bus.BUSYWAIT) begin
                done = 1;
            end else begin
                busy++;
                if (bus.MEM_READ)
                    chk("mem_addr", {4'h0, bus.MEM_ADDRESS}, {4'h0, addr[31:4]});
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("fetch_timeout", 32'd0, 32'd1);
        chk("busy_cycles", busy, exp_miss ? LAT + 3 : 0);
        chk("mem_read_on_hit", {31'd0, bus.MEM_READ}, 32'd0);
        e = sbq.pop_front();
        chk("insn", bus.INSTRUCTION, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit done;
        bit switched;
        rst = 1'b0;
        bus.READ = 1'b1;
        bus.ADDRESS = 32'h100;

        tbl[0] = '{32'h00, 1'b1, word_of(32'h00)};
        tbl[1] = '{32'h04, 1'b0, word_of(32'h04)};
        tbl[2] = '{32'h08, 1'b0, word_of(32'h08)};
        tbl[3] = '{32'h0C, 1'b0, word_of(32'h0C)};
        tbl[4] = '{32'h80, 1'b1, word_of(32'h80)};
        tbl[5] = '{32'h00, 1'b1, word_of(32'h00)};
        tbl[6] = '{32'h84, 1'b1, word_of(32'h84)};
        tbl[7] = '{32'h3C, 1'b1, word_of(32'h3C)};
        tbl[8] = '{32'h38, 1'b0, word_of(32'h38)};
        tbl[9] = '{32'h00, 1'b1, word_of(32'h00)};

        // reset held for two edges with a request pending
        @(posedge clk);
        @(negedge clk);
        chk("rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        chk("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        @(posedge clk);
        #1;
        bus.READ = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) fetch(tbl[i].addr, tbl[i].miss, tbl[i].insn);

        // PC changes while the block for 0x10 is in flight
        bus.READ = 1'b1;
        bus.ADDRESS = 32'h10;
        sbq.push_back(word_of(32'h20));
        seen.delete();
        done = 0;
        switched = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!bus.BUSYWAIT) begin
                done = 1;
            end else begin
                if (bus.MEM_READ) begin
                    if (seen.size() == 0 || seen[$] != bus.MEM_ADDRESS)
                        seen.push_back(bus.MEM_ADDRESS);
                    if (!switched) begin
                        switched = 1;
                        bus.ADDRESS = 32'h20;
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("midmiss_timeout", 32'd0, 32'd1);
        chk("midmiss_fills", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            chk("midmiss_first", {4'h0, seen[0]}, 32'h1);
            chk("midmiss_second", {4'h0, seen[1]}, 32'h2);
        end
        chk("midmiss_insn", bus.INSTRUCTION, sbq.pop_front());
        @(posedge clk);
        #1;
        fetch(32'h10, 1'b0, word_of(32'h10));
        fetch(32'h00, 1'b0, word_of(32'h00));

        // reset asserted while a refill is outstanding
        bus.READ = 1'b1;
        bus.ADDRESS = 32'h40;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.MEM_READ) done = 1;
        end
        if (!done) chk("rst_mid_timeout", 32'd0, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("rst_mid_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        bus.READ = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        fetch(32'h00, 1'b1, word_of(32'h00));

        // idle with an uncached PC and no request
        bus.READ = 1'b0;
        bus.ADDRESS = 32'h100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rdlow_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
            chk("rdlow_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage (PC side) and the 128-bit-block instruction memory (memory side).
- On a hit it returns the 32-bit instruction combinationally in the same cycle.
- On a miss it stalls the CPU with BUSYWAIT, fetches one 16-byte block through the memory's READ/BUSYWAIT handshake, installs it, then serves the hit.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines of 128 bits).
- TAG_BITS, 32-4-INDEX_BITS (default 25), derived; stored tag width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset (RESET==0 at a rising CLK edge resets).
- READ  input  1  fetch request from the CPU.
- ADDRESS  input  32  byte PC; bits [1:0] ignored.
- INSTRUCTION  output  32  selected word of the hit line.
- BUSYWAIT  output  1  CPU stall.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address to memory, equal to PC[31:4].
- MEM_READDATA  input  128  block from memory; byte 0 is in [7:0].
- MEM_BUSYWAIT  input  1  memory busy; rises combinationally with MEM_READ and falls when data is valid.

Behaviour:
- Address split:
  - offset = ADDRESS[3:2] selects the word: 0 → [31:0], 1 → [63:32], 2 → [95:64], 3 → [127:96].
  - index = ADDRESS[4+INDEX_BITS-1:4].
  - tag = ADDRESS[31:4+INDEX_BITS].
- Storage per line: valid bit, tag, 128-bit data.
- hit = READ & valid[index] & (tag_array[index]==tag); combinational.
- INSTRUCTION = word(offset) of data[index], combinational. It is don't-care when hit==0 and must not be X-checked.
- BUSYWAIT = READ & ~hit in IDLE; 1 in MEM_READ and UPDATE; forced 0 while RESET==0.
- FSM states:
  - IDLE: MEM_READ=0. At an edge where READ & ~hit, latch miss_block = ADDRESS[31:4] and go to MEM_READ.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS=miss_block. At an edge where MEM_BUSYWAIT==0, capture MEM_READDATA into a fill register and go to UPDATE. The first cycle normally sees MEM_BUSYWAIT=1 because memory raises it from MEM_READ.
  - UPDATE: MEM_READ=0. Write the fill data, tag miss_block[27:INDEX_BITS] and valid=1 into line miss_block[INDEX_BITS-1:0]. Go to IDLE.
  - The following IDLE cycle re-evaluates hit on the current ADDRESS.
- Miss penalty: 1 cycle to enter MEM_READ, plus the memory wait cycles, plus 1 UPDATE cycle, plus the hit cycle.
- MEM_ADDRESS outside MEM_READ: drives miss_block; value is don't-care.
- ADDRESS or READ changing during MEM_READ/UPDATE is ignored. The fill always completes for the latched block. If the CPU's PC then differs, a new lookup occurs in IDLE.
- READ==0 in IDLE: no state change; BUSYWAIT=0.
- Replacement: an install overwrites the line unconditionally. There is no dirty state and no write path.
- Reset (RESET==0 at an edge, any state including mid-miss):
  - all valid bits cleared; state goes to IDLE; MEM_READ=0 from the next cycle.
  - any in-flight block is discarded.
  - tag and data arrays are not reset.
- Aliasing: two PCs with equal index and different tag evict each other. Each access after an eviction is a full miss.

Decomposition:
- Shared package icache_pkg holds:
  - state encoding constants IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2;
  - BLOCK_WIDTH=128, WORD_WIDTH=32, OFFSET_BITS=2, BYTE_OFFSET_BITS=4.
- One natural sub-module, icache_word_select: a 128→32 mux on offset. The FSM and arrays stay in the top.

Test Plan:
- Cold miss: reset low for 2 cycles then high, READ=1, ADDRESS=32'h0000_0000, memory block 0 words = 32'h11111111..32'h44444444.
  - Required: BUSYWAIT=1 immediately; MEM_READ=1 with MEM_ADDRESS=28'h0000000 until memory BUSYWAIT falls.
  - Required: one UPDATE cycle, then INSTRUCTION=32'h11111111 with BUSYWAIT=0.
- Same-block hits: ADDRESS=32'h4, 32'h8, 32'hC on consecutive cycles.
  - Required: INSTRUCTION = 32'h22222222, 32'h33333333, 32'h44444444.
  - Required: BUSYWAIT=0 throughout and MEM_READ never asserted.
- Conflict eviction (INDEX_BITS=3):
  - Fetch 32'h00000000, then 32'h00000080 (same index 0, tag 1). Required: second access misses with MEM_ADDRESS=28'h0000008.
  - Re-fetch 32'h00000000. Required: misses again with MEM_ADDRESS=28'h0000000.
- PC change mid-miss: miss on 32'h00000010, then change ADDRESS to 32'h00000020 during MEM_READ.
  - Required: fill completes to line 1 with MEM_ADDRESS=28'h0000001.
  - Required: a new miss follows for MEM_ADDRESS=28'h0000002; line 1 is then a hit.
- Reset mid-miss: RESET=0 while in MEM_READ.
  - Required next cycle: MEM_READ=0, BUSYWAIT=0, state IDLE.
  - Required after release: a previously cached PC such as 32'h0 misses again, confirming valid bits were cleared.
- READ low: READ=0 with an uncached ADDRESS=32'h00000100 for 5 cycles.
  - Required: BUSYWAIT=0 and MEM_READ=0 throughout.
